// File: rtl/filter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_mem_pkg
// Description : Shared types and constants for the filter buffer memory
//               controller and its read-port sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_mem_pkg;

    // Default buffer geometry used by the shared typedefs
    localparam int unsigned c_addr_width = 15;
    localparam int unsigned c_data_width = 32;

    // Entries in each read channel's output FIFO
    localparam int unsigned RD_FIFO_DEPTH = 2;

    typedef logic [c_addr_width-1:0] addr_t;
    typedef logic [c_data_width-1:0] data_t;

    // Source of the most recent accepted memory write
    typedef enum logic {
        SRC_RX = 1'b0,
        SRC_PL = 1'b1
    } wr_src_e;

endpackage : filter_mem_pkg
`default_nettype wire

// File: rtl/filter_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : filter_rd_port
// Description : One filter TX read channel. Issues grants against a 2-word
//               credit (queued words + word in flight), tracks the 1-cycle
//               memory read latency, buffers returned words in a 2-entry
//               fall-through FIFO and stalls on read-after-write hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_rd_port
    import filter_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_gnt,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr
);

    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_store [RD_FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_empty_st;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic [2:0]            w_pending;
    logic                  w_hazard;
    logic                  w_gnt;
    logic                  w_push_st;
    logic                  w_pop_st;

    // The word arriving from memory counts as FIFO content: it is presented
    // directly (fall-through) when nothing older is queued, so data appears
    // one cycle after its grant.
    assign w_empty_st = (r_count == 2'd0);
    assign o_valid    = r_inflight | ~w_empty_st;
    assign w_head     = w_empty_st ? i_mem_rdata : r_store[r_rd_ptr];
    assign o_data     = o_valid ? w_head : '0;
    assign w_pop      = o_valid & i_ready;

    // Words owed to the consumer after this cycle's pop; must leave room
    // for the word a new grant would bring back.
    assign w_pending  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // A write sitting on the memory write port this cycle has not landed yet,
    // so a read of the same address must wait one cycle.
    assign w_hazard   = i_wr_en & (i_wr_addr == i_addr);

    assign w_gnt      = i_req & ~w_hazard & (w_pending < 3'(RD_FIFO_DEPTH));
    assign o_gnt      = w_gnt & ~rst;

    // Address tracks the request while granting, otherwise holds the last one
    assign o_mem_raddr = o_gnt ? i_addr : r_last_addr;

    // Arriving word is stored unless it is consumed straight through
    assign w_push_st  = r_inflight & ~(w_pop & w_empty_st);
    assign w_pop_st   = w_pop & ~w_empty_st;

    // In-flight flag and last granted address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_inflight <= w_gnt;
            if (w_gnt) begin
                r_last_addr <= i_addr;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_store[0] <= '0;
            r_store[1] <= '0;
        end else begin
            if (w_push_st) begin
                r_store[r_wr_ptr] <= i_mem_rdata;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop_st) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_st} - {1'b0, w_pop_st};
        end
    end

endmodule : filter_rd_port
`default_nettype wire

// File: rtl/filter_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : filter_mem_ctrl
// Description : Controller between the uDMA filter engine and its dual-read
//               buffer memory. Two flow-controlled read channels, a
//               round-robin shared write port (filter RX vs host preload)
//               and a counter of accepted RX writes.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_mem_ctrl
    import filter_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned L2_AWIDTH_NOAL = 15,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // read channel 0
    input  logic                      ch0_req_i,
    input  logic [L2_AWIDTH_NOAL-1:0] ch0_addr_i,
    output logic                      ch0_gnt_o,
    output logic                      ch0_valid_o,
    output logic [DATA_WIDTH-1:0]     ch0_data_o,
    input  logic                      ch0_ready_i,
    // read channel 1
    input  logic                      ch1_req_i,
    input  logic [L2_AWIDTH_NOAL-1:0] ch1_addr_i,
    output logic                      ch1_gnt_o,
    output logic                      ch1_valid_o,
    output logic [DATA_WIDTH-1:0]     ch1_data_o,
    input  logic                      ch1_ready_i,
    // filter result writes
    input  logic                      rx_valid_i,
    input  logic [L2_AWIDTH_NOAL-1:0] rx_addr_i,
    input  logic [DATA_WIDTH-1:0]     rx_data_i,
    output logic                      rx_ready_o,
    // host preload writes
    input  logic                      pl_valid_i,
    input  logic [L2_AWIDTH_NOAL-1:0] pl_addr_i,
    input  logic [DATA_WIDTH-1:0]     pl_data_i,
    output logic                      pl_ready_o,
    // buffer memory
    output logic                      mem_we_o,
    output logic [L2_AWIDTH_NOAL-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [L2_AWIDTH_NOAL-1:0] mem_raddr_a_o,
    output logic [L2_AWIDTH_NOAL-1:0] mem_raddr_b_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_a_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_b_i,
    // status
    input  logic                      cnt_clr_i,
    output logic [CNT_WIDTH-1:0]      wr_cnt_o
);

    wr_src_e                   r_last_src;
    logic                      r_mem_we;
    logic [L2_AWIDTH_NOAL-1:0] r_mem_waddr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic [CNT_WIDTH-1:0]      r_wr_cnt;

    logic                      w_rx_acc;
    logic                      w_pl_acc;

    // ------------------------------------------------------------------
    // Read channels: port A serves ch0, port B serves ch1
    // ------------------------------------------------------------------
    filter_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (L2_AWIDTH_NOAL)
    ) u_rd_ch0 (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_req       (ch0_req_i),
        .i_addr      (ch0_addr_i),
        .o_gnt       (ch0_gnt_o),
        .o_valid     (ch0_valid_o),
        .o_data      (ch0_data_o),
        .i_ready     (ch0_ready_i),
        .o_mem_raddr (mem_raddr_a_o),
        .i_mem_rdata (mem_rdata_a_i),
        .i_wr_en     (r_mem_we),
        .i_wr_addr   (r_mem_waddr)
    );

    filter_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (L2_AWIDTH_NOAL)
    ) u_rd_ch1 (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_req       (ch1_req_i),
        .i_addr      (ch1_addr_i),
        .o_gnt       (ch1_gnt_o),
        .o_valid     (ch1_valid_o),
        .o_data      (ch1_data_o),
        .i_ready     (ch1_ready_i),
        .o_mem_raddr (mem_raddr_b_o),
        .i_mem_rdata (mem_rdata_b_i),
        .i_wr_en     (r_mem_we),
        .i_wr_addr   (r_mem_waddr)
    );

    // ------------------------------------------------------------------
    // Write arbitration: a lone requester always wins; under contention
    // the requester that did not win last time is served.
    // ------------------------------------------------------------------
    assign w_rx_acc   = rx_valid_i & (~pl_valid_i | (r_last_src == SRC_PL));
    assign w_pl_acc   = pl_valid_i & (~rx_valid_i | (r_last_src == SRC_RX));

    assign rx_ready_o = w_rx_acc & ~rst_i;
    assign pl_ready_o = w_pl_acc & ~rst_i;

    // Register the winning write onto the memory port and remember the winner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_src  <= SRC_PL;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_rx_acc | w_pl_acc;
            if (w_rx_acc) begin
                r_last_src  <= SRC_RX;
                r_mem_waddr <= rx_addr_i;
                r_mem_wdata <= rx_data_i;
            end else if (w_pl_acc) begin
                r_last_src  <= SRC_PL;
                r_mem_waddr <= pl_addr_i;
                r_mem_wdata <= pl_data_i;
            end
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_waddr_o = r_mem_waddr;
    assign mem_wdata_o = r_mem_wdata;

    // Count accepted RX writes; clear wins over a same-cycle increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_wr_cnt <= '0;
        end else if (w_rx_acc) begin
            r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
        end
    end

    assign wr_cnt_o = r_wr_cnt;

endmodule : filter_mem_ctrl
`default_nettype wire

// File: tb/tb_filter_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_filter_mem_ctrl
// Description : Directed self-checking bench for filter_mem_ctrl with a
//               behavioural dual-read buffer memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ch0_req_i, ch0_gnt_o, ch0_valid_o, ch0_ready_i;
    logic [AW-1:0] ch0_addr_i;
    logic [DW-1:0] ch0_data_o;
    logic          ch1_req_i, ch1_gnt_o, ch1_valid_o, ch1_ready_i;
    logic [AW-1:0] ch1_addr_i;
    logic [DW-1:0] ch1_data_o;
    logic          rx_valid_i, rx_ready_o, pl_valid_i, pl_ready_o;
    logic [AW-1:0] rx_addr_i, pl_addr_i;
    logic [DW-1:0] rx_data_i, pl_data_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o, mem_raddr_a_o, mem_raddr_b_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_a_i, mem_rdata_b_i;
    logic          cnt_clr_i;
    logic [CW-1:0] wr_cnt_o;

    logic          mem_init;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    filter_mem_ctrl #(
        .DATA_WIDTH     (DW),
        .L2_AWIDTH_NOAL (AW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i (clk), .rst_i (rst_i),
        .ch0_req_i (ch0_req_i), .ch0_addr_i (ch0_addr_i), .ch0_gnt_o (ch0_gnt_o),
        .ch0_valid_o (ch0_valid_o), .ch0_data_o (ch0_data_o), .ch0_ready_i (ch0_ready_i),
        .ch1_req_i (ch1_req_i), .ch1_addr_i (ch1_addr_i), .ch1_gnt_o (ch1_gnt_o),
        .ch1_valid_o (ch1_valid_o), .ch1_data_o (ch1_data_o), .ch1_ready_i (ch1_ready_i),
        .rx_valid_i (rx_valid_i), .rx_addr_i (rx_addr_i), .rx_data_i (rx_data_i), .rx_ready_o (rx_ready_o),
        .pl_valid_i (pl_valid_i), .pl_addr_i (pl_addr_i), .pl_data_i (pl_data_i), .pl_ready_o (pl_ready_o),
        .mem_we_o (mem_we_o), .mem_waddr_o (mem_waddr_o), .mem_wdata_o (mem_wdata_o),
        .mem_raddr_a_o (mem_raddr_a_o), .mem_raddr_b_o (mem_raddr_b_o),
        .mem_rdata_a_i (mem_rdata_a_i), .mem_rdata_b_i (mem_rdata_b_i),
        .cnt_clr_i (cnt_clr_i), .wr_cnt_o (wr_cnt_o)
    );

    // Buffer memory: one write port, two synchronous read ports, read-before-write
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else if (mem_we_o) begin
            mem[mem_waddr_o] <= mem_wdata_o;
        end
        mem_rdata_a_i <= mem[mem_raddr_a_o];
        mem_rdata_b_i <= mem[mem_raddr_b_o];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; mem_init = 1'b1; cnt_clr_i = 1'b0;
        ch0_req_i = 1'b1; ch0_addr_i = 15'h5; ch0_ready_i = 1'b0;
        ch1_req_i = 1'b1; ch1_addr_i = 15'h6; ch1_ready_i = 1'b0;
        rx_valid_i = 1'b1; rx_addr_i = 15'h7; rx_data_i = 32'h1;
        pl_valid_i = 1'b1; pl_addr_i = 15'h8; pl_data_i = 32'h2;
        #2;
        n_checks++; if (ch0_gnt_o !== 1'b0) begin $display("FAIL reset_ch0_gnt: got %b expected 0", ch0_gnt_o); n_errors++; end
        n_checks++; if (ch1_gnt_o !== 1'b0) begin $display("FAIL reset_ch1_gnt: got %b expected 0", ch1_gnt_o); n_errors++; end
        n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL reset_ch0_valid: got %b expected 0", ch0_valid_o); n_errors++; end
        n_checks++; if (ch1_valid_o !== 1'b0) begin $display("FAIL reset_ch1_valid: got %b expected 0", ch1_valid_o); n_errors++; end
        n_checks++; if (rx_ready_o !== 1'b0) begin $display("FAIL reset_rx_ready: got %b expected 0", rx_ready_o); n_errors++; end
        n_checks++; if (pl_ready_o !== 1'b0) begin $display("FAIL reset_pl_ready: got %b expected 0", pl_ready_o); n_errors++; end
        n_checks++; if (mem_we_o !== 1'b0) begin $display("FAIL reset_mem_we: got %b expected 0", mem_we_o); n_errors++; end
        n_checks++; if (mem_waddr_o !== 15'h0) begin $display("FAIL reset_mem_waddr: got %h expected 0", mem_waddr_o); n_errors++; end
        n_checks++; if (mem_wdata_o !== 32'h0) begin $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata_o); n_errors++; end
        n_checks++; if (mem_raddr_a_o !== 15'h0) begin $display("FAIL reset_raddr_a: got %h expected 0", mem_raddr_a_o); n_errors++; end
        n_checks++; if (ch0_data_o !== 32'h0) begin $display("FAIL reset_ch0_data: got %h expected 0", ch0_data_o); n_errors++; end
        n_checks++; if (wr_cnt_o !== 16'h0) begin $display("FAIL reset_wr_cnt: got %h expected 0", wr_cnt_o); n_errors++; end
        @(posedge clk);
        step();
        ch0_req_i = 1'b0; ch1_req_i = 1'b0; rx_valid_i = 1'b0; pl_valid_i = 1'b0;
        mem_init = 1'b0; rst_i = 1'b0;
        step();
    endtask

    // Preload 0..3 with A0..A3, then stream them back on ch0
    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            pl_valid_i = 1'b1; pl_addr_i = 15'(k); pl_data_i = 32'hA0 + 32'(k);
            @(negedge clk);
            n_checks++; if (pl_ready_o !== 1'b1) begin $display("FAIL preload_ready%0d: got %b expected 1", k, pl_ready_o); n_errors++; end
            step();
        end
        pl_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_we_o !== 1'b1 || mem_waddr_o !== 15'h3 || mem_wdata_o !== 32'hA3) begin
            $display("FAIL preload_last_write: got we=%b addr=%h data=%h expected we=1 addr=3 data=a3", mem_we_o, mem_waddr_o, mem_wdata_o); n_errors++; end
        step();
        ch0_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ch0_req_i = (k < 4); ch0_addr_i = 15'(k);
            @(negedge clk);
            if (k < 4) begin
                n_checks++; if (ch0_gnt_o !== 1'b1) begin $display("FAIL stream_gnt%0d: got %b expected 1", k, ch0_gnt_o); n_errors++; end
            end
            if (k == 0) begin
                n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL stream_valid0: got %b expected 0", ch0_valid_o); n_errors++; end
            end else begin
                n_checks++; if (ch0_valid_o !== 1'b1 || ch0_data_o !== 32'hA0 + 32'(k-1)) begin
                    $display("FAIL stream_data%0d: got valid=%b data=%h expected valid=1 data=%h", k, ch0_valid_o, ch0_data_o, 32'hA0 + 32'(k-1)); n_errors++; end
            end
            step();
        end
        ch0_req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL stream_drained: got valid=%b expected 0", ch0_valid_o); n_errors++; end
        step();
    endtask

    // ch1 with the consumer stalled, then released
    task automatic test_backpressure();
        logic       t_req   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic [1:0] t_addr  [9] = '{0, 1, 2, 2, 2, 3, 3, 3, 3};
        logic       t_rdy   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic       t_gnt   [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        logic       t_vld   [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] t_data  [9] = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        for (int k = 0; k < 9; k++) begin
            ch1_req_i = t_req[k]; ch1_addr_i = 15'(t_addr[k]); ch1_ready_i = t_rdy[k];
            @(negedge clk);
            n_checks++; if (ch1_gnt_o !== t_gnt[k]) begin $display("FAIL bp_gnt%0d: got %b expected %b", k, ch1_gnt_o, t_gnt[k]); n_errors++; end
            n_checks++; if (ch1_valid_o !== t_vld[k]) begin $display("FAIL bp_valid%0d: got %b expected %b", k, ch1_valid_o, t_vld[k]); n_errors++; end
            if (t_vld[k]) begin
                n_checks++; if (ch1_data_o !== {24'h0, t_data[k]}) begin $display("FAIL bp_data%0d: got %h expected %h", k, ch1_data_o, t_data[k]); n_errors++; end
            end
            step();
        end
        ch1_req_i = 1'b0;
    endtask

    // Both writers active for 6 cycles: RX, PL, RX, PL, RX, PL
    task automatic test_contention();
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rx_valid_i = (k < 6); rx_addr_i = 15'h20 + 15'(k); rx_data_i = 32'h1000 + 32'(k);
            pl_valid_i = (k < 6); pl_addr_i = 15'h40 + 15'(k); pl_data_i = 32'h2000 + 32'(k);
            @(negedge clk);
            n_checks++; if (rx_ready_o !== (k < 6 && k % 2 == 0)) begin $display("FAIL arb_rx_ready%0d: got %b expected %b", k, rx_ready_o, (k < 6 && k % 2 == 0)); n_errors++; end
            n_checks++; if (pl_ready_o !== (k < 6 && k % 2 == 1)) begin $display("FAIL arb_pl_ready%0d: got %b expected %b", k, pl_ready_o, (k < 6 && k % 2 == 1)); n_errors++; end
            exp_we = (k >= 1 && k <= 6);
            n_checks++; if (mem_we_o !== exp_we) begin $display("FAIL arb_we%0d: got %b expected %b", k, mem_we_o, exp_we); n_errors++; end
            if (exp_we) begin
                exp_addr = ((k-1) % 2 == 0) ? 15'h20 + 15'(k-1) : 15'h40 + 15'(k-1);
                exp_data = ((k-1) % 2 == 0) ? 32'h1000 + 32'(k-1) : 32'h2000 + 32'(k-1);
                n_checks++; if (mem_waddr_o !== exp_addr || mem_wdata_o !== exp_data) begin
                    $display("FAIL arb_wr%0d: got addr=%h data=%h expected addr=%h data=%h", k, mem_waddr_o, mem_wdata_o, exp_addr, exp_data); n_errors++; end
            end
            step();
        end
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'd3) begin $display("FAIL arb_wr_cnt: got %0d expected 3", wr_cnt_o); n_errors++; end
        step();
    endtask

    // Read of an address whose write is on the memory port this cycle
    task automatic test_raw();
        ch0_ready_i = 1'b1;
        rx_valid_i = 1'b1; rx_addr_i = 15'h10; rx_data_i = 32'h55;
        @(negedge clk);
        n_checks++; if (rx_ready_o !== 1'b1) begin $display("FAIL raw_rx_ready: got %b expected 1", rx_ready_o); n_errors++; end
        step();
        rx_valid_i = 1'b0; ch0_req_i = 1'b1; ch0_addr_i = 15'h10;
        @(negedge clk);
        n_checks++; if (mem_we_o !== 1'b1) begin $display("FAIL raw_we: got %b expected 1", mem_we_o); n_errors++; end
        n_checks++; if (ch0_gnt_o !== 1'b0) begin $display("FAIL raw_gnt_stall: got %b expected 0", ch0_gnt_o); n_errors++; end
        step();
        @(negedge clk);
        n_checks++; if (ch0_gnt_o !== 1'b1) begin $display("FAIL raw_gnt_retry: got %b expected 1", ch0_gnt_o); n_errors++; end
        step();
        ch0_req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ch0_valid_o !== 1'b1 || ch0_data_o !== 32'h55) begin
            $display("FAIL raw_data: got valid=%b data=%h expected valid=1 data=55", ch0_valid_o, ch0_data_o); n_errors++; end
        step();
        @(negedge clk);
        n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL raw_drained: got %b expected 0", ch0_valid_o); n_errors++; end
        step();
    endtask

    // Wrap at 0xFFFF, clear priority, preload not counted
    task automatic test_counter();
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'h0) begin $display("FAIL cnt_clear: got %h expected 0", wr_cnt_o); n_errors++; end
        rx_valid_i = 1'b1; rx_addr_i = 15'h80; rx_data_i = 32'h77;
        step();
        repeat (65534) @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'hFFFF) begin $display("FAIL cnt_full: got %h expected ffff", wr_cnt_o); n_errors++; end
        step();
        rx_valid_i = 1'b1;
        step();
        rx_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'h0) begin $display("FAIL cnt_wrap: got %h expected 0", wr_cnt_o); n_errors++; end
        step();
        rx_valid_i = 1'b1; cnt_clr_i = 1'b1;
        step();
        rx_valid_i = 1'b1; cnt_clr_i = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'h0) begin $display("FAIL cnt_clr_vs_inc: got %h expected 0", wr_cnt_o); n_errors++; end
        step();
        rx_valid_i = 1'b0; pl_valid_i = 1'b1; pl_addr_i = 15'h81; pl_data_i = 32'h99;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'h1) begin $display("FAIL cnt_after_inc: got %h expected 1", wr_cnt_o); n_errors++; end
        step();
        pl_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_cnt_o !== 16'h1) begin $display("FAIL cnt_pl_ignored: got %h expected 1", wr_cnt_o); n_errors++; end
        step();
    endtask

    // Asynchronous reset with ch0 holding one word and one in flight
    task automatic test_midreset();
        ch0_ready_i = 1'b0;
        ch0_req_i = 1'b1; ch0_addr_i = 15'h0;
        step();
        ch0_addr_i = 15'h1; rx_valid_i = 1'b1; rx_addr_i = 15'h90; rx_data_i = 32'h3;
        step();
        ch0_req_i = 1'b0; rx_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ch0_valid_o !== 1'b1 || mem_we_o !== 1'b1) begin
            $display("FAIL mr_pre: got valid=%b we=%b expected valid=1 we=1", ch0_valid_o, mem_we_o); n_errors++; end
        #1;
        ch0_req_i = 1'b1; ch0_addr_i = 15'h2; rx_valid_i = 1'b1; pl_valid_i = 1'b1; rst_i = 1'b1;
        #1;
        n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL mr_valid: got %b expected 0", ch0_valid_o); n_errors++; end
        n_checks++; if (ch0_gnt_o !== 1'b0) begin $display("FAIL mr_gnt: got %b expected 0", ch0_gnt_o); n_errors++; end
        n_checks++; if (ch0_data_o !== 32'h0) begin $display("FAIL mr_data: got %h expected 0", ch0_data_o); n_errors++; end
        n_checks++; if (mem_we_o !== 1'b0) begin $display("FAIL mr_we: got %b expected 0", mem_we_o); n_errors++; end
        n_checks++; if (rx_ready_o !== 1'b0 || pl_ready_o !== 1'b0) begin $display("FAIL mr_ready: got rx=%b pl=%b expected 0 0", rx_ready_o, pl_ready_o); n_errors++; end
        n_checks++; if (wr_cnt_o !== 16'h0) begin $display("FAIL mr_cnt: got %h expected 0", wr_cnt_o); n_errors++; end
        step();
        ch0_req_i = 1'b0; rx_valid_i = 1'b0; pl_valid_i = 1'b0; rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (ch0_valid_o !== 1'b0) begin $display("FAIL mr_stale%0d: got %b expected 0", k, ch0_valid_o); n_errors++; end
            step();
        end
        rx_valid_i = 1'b1; pl_valid_i = 1'b1; rx_addr_i = 15'h91; pl_addr_i = 15'h92;
        @(negedge clk);
        n_checks++; if (rx_ready_o !== 1'b1 || pl_ready_o !== 1'b0) begin
            $display("FAIL mr_rr_favours_rx: got rx=%b pl=%b expected 1 0", rx_ready_o, pl_ready_o); n_errors++; end
        step();
        rx_valid_i = 1'b0; pl_valid_i = 1'b0;
        ch0_ready_i = 1'b1; ch0_req_i = 1'b1; ch0_addr_i = 15'h1;
        @(negedge clk);
        n_checks++; if (ch0_gnt_o !== 1'b1) begin $display("FAIL mr_read_gnt: got %b expected 1", ch0_gnt_o); n_errors++; end
        step();
        ch0_req_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ch0_valid_o !== 1'b1 || ch0_data_o !== 32'hA1) begin
            $display("FAIL mr_read_data: got valid=%b data=%h expected valid=1 data=a1", ch0_valid_o, ch0_data_o); n_errors++; end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_contention();
        test_raw();
        test_counter();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_filter_mem_ctrl
`default_nettype wire

// File: doc/filter_mem_ctrl.md
Name: filter_mem_ctrl

Overview:
- Controller between the uDMA filter engine and its dual-read buffer memory (one write port, two synchronous read ports, 1-cycle read latency).
- Gives the two filter TX read channels a proper req/gnt and valid/ready protocol, including backpressure and read-after-write hazard stalls.
- Shares the single memory write port between the filter RX stream and a host preload port using round-robin arbitration.
- Keeps a write counter for status.

Parameters:
- DATA_WIDTH, 32, data word width.
- L2_AWIDTH_NOAL, 15, buffer word-address width.
- CNT_WIDTH, 16, width of the write counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ch0_req_i  in  1  read request, channel 0
- ch0_addr_i  in  L2_AWIDTH_NOAL  read address, channel 0
- ch0_gnt_o  out  1  request accepted, channel 0
- ch0_valid_o  out  1  read data valid, channel 0
- ch0_data_o  out  DATA_WIDTH  read data, channel 0
- ch0_ready_i  in  1  consumer accepts data, channel 0
- ch1_req_i, ch1_addr_i, ch1_gnt_o, ch1_valid_o, ch1_data_o, ch1_ready_i: same as ch0, for channel 1
- rx_valid_i  in  1  filter result write request
- rx_addr_i  in  L2_AWIDTH_NOAL  filter result write address
- rx_data_i  in  DATA_WIDTH  filter result write data
- rx_ready_o  out  1  filter result write accepted
- pl_valid_i, pl_addr_i, pl_data_i, pl_ready_o: host preload write port, same widths and meaning as rx_*
- mem_we_o  out  1  memory write enable
- mem_waddr_o  out  L2_AWIDTH_NOAL  memory write address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_raddr_a_o  out  L2_AWIDTH_NOAL  memory read port A address (serves ch0)
- mem_raddr_b_o  out  L2_AWIDTH_NOAL  memory read port B address (serves ch1)
- mem_rdata_a_i  in  DATA_WIDTH  memory read port A data
- mem_rdata_b_i  in  DATA_WIDTH  memory read port B data
- cnt_clr_i  in  1  synchronous clear of the write counter
- wr_cnt_o  out  CNT_WIDTH  count of accepted RX writes

Behaviour:

Reset (rst_i high, asynchronous):
- All gnt/valid/ready/we outputs are 0; addresses, data and wr_cnt_o are 0.
- Read FIFOs are emptied, in-flight flags are cleared, and the round-robin pointer is set to favour RX.
- Asserting reset mid-operation drops any in-flight read and any queued data.

Read channel (ch0 shown; ch1 is identical on port B):
- Each channel has a 2-entry output FIFO and an in-flight flag.
- gnt = req_i & ~hazard & (occ + inflight - pop < 2), where pop = valid_o & ready_i.
- mem_raddr_a_o = ch0_addr_i, combinational. It is held at the last granted address when there is no grant.
- A grant in cycle N sets inflight for cycle N+1. In cycle N+1, mem_rdata_a_i is pushed into the FIFO.
- valid_o = FIFO not empty; data_o = FIFO head.
- Back-to-back grants sustain 1 word per cycle while ready_i=1. With ready_i=0, at most 2 grants are issued, then gnt drops.
- Simultaneous push and pop: occupancy is unchanged.
- Hazard: hazard = mem_we_o & (mem_waddr_o == addr_i). gnt is withheld for that cycle; a read never returns stale data for a write already accepted.

Write arbitration:
- A request is rx_valid_i or pl_valid_i.
- One request pending: that requester is granted.
- Both pending: the requester not granted last is granted (round-robin).
- ready_o is combinational from valid_i and the arbiter state, so at most one of rx_ready_o / pl_ready_o is high per cycle.
- The accepted address and data are registered into mem_waddr_o / mem_wdata_o, with mem_we_o=1 in the next cycle (1-cycle write latency).
- The write path has no stall source; writes sustain 1 per cycle.

Counter:
- wr_cnt_o increments on each accepted RX write and wraps modulo 2^CNT_WIDTH.
- cnt_clr_i has priority over the increment; clear and accept in the same cycle gives 0.
- Preload writes are not counted.

Decomposition:
- Package filter_mem_pkg:
  - addr_t and data_t typedefs
  - RD_FIFO_DEPTH=2
  - wr_src_e enum {SRC_RX, SRC_PL}
- Sub-module filter_rd_port: request credit logic, in-flight flag, 2-entry FIFO and hazard compare. It is instantiated twice.
- The write arbiter and counter sit in the top level.

Test Plan:
1. Streaming read: preload addr 0..3 with 0xA0..0xA3; ch0 requests addr 0..3 back-to-back with ready=1 -> gnt every cycle, valid 1 cycle after each gnt, data 0xA0..0xA3 in order.
2. Backpressure: ch1 requests continuously, ready=0 -> exactly 2 gnts, then gnt=0, valid=1 held with data stable; ready=1 -> both words drain and requests resume with no loss.
3. Write contention: rx and pl valid every cycle for 6 cycles -> grants alternate RX, PL, RX, …; mem_we_o=1 for 6 consecutive cycles starting 1 cycle later; wr_cnt_o=3.
4. RAW hazard: RX writes 0x55 to addr 0x10 while ch0 requests 0x10 in the same cycle -> gnt deferred 1 cycle; returned data = 0x55.
5. Counter boundaries: with CNT_WIDTH=16, start from 0xFFFF and accept 1 RX write -> 0x0000; cnt_clr_i together with an accepted write -> 0.
6. Mid-operation reset: assert rst_i with one read in flight and the FIFO holding 1 word -> all valid/gnt/we outputs are 0 immediately (asynchronously); after release no stale valid appears.
